// File: rtl/lynx_mem_pkg.sv
// rtl/lynx_mem_pkg.sv - shared types and defaults for the Lynx RAM arbiter
package lynx_mem_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        VID,
        CPU_RD,
        CPU_WR,
        DL_WR
    } grant_t;

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } dl_entry_t;

endpackage

// File: rtl/lynx_dl_fifo.sv
// rtl/lynx_dl_fifo.sv - download byte FIFO; a pop frees a slot for a same-cycle push
module lynx_dl_fifo
    import lynx_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk_sys,
    input  logic      reset_n,
    input  logic      push,
    input  dl_entry_t push_data,
    input  logic      pop,
    output dl_entry_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int PW = $clog2(FIFO_DEPTH);

    dl_entry_t     store [FIFO_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = store[rd_ptr[PW-1:0]];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) store[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/lynx_mem_arbiter.sv
// rtl/lynx_mem_arbiter.sv - single-port RAM arbiter: video > aged CPU > download > CPU
module lynx_mem_arbiter
    import lynx_mem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_data,
    output logic          dl_busy,
    output logic          dl_overflow,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    grant_t        state;
    grant_t        grant;
    logic          pend_valid;
    logic          pend_we;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_din;
    logic [WW-1:0] wait_cnt;
    logic          cpu_grant;
    logic [DW-1:0] cpu_dout_q;
    logic          dl_prev;

    dl_entry_t     fifo_in;
    dl_entry_t     fifo_out;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;

    // Bytes above the RAM window are discarded before they reach the FIFO
    assign fifo_push    = ioctl_wr && (ioctl_addr[24:AW] == '0);
    assign fifo_in.addr = DEF_AW'(ioctl_addr[AW-1:0]);
    assign fifo_in.data = ioctl_data;
    assign fifo_pop     = (grant == DL_WR);

    lynx_dl_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_dl_fifo (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        grant    = IDLE;
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_din  = '0;
        if (vid_req)
            grant = VID;
        else if (pend_valid && wait_cnt >= WW'(MAX_WAIT))
            grant = pend_we ? CPU_WR : CPU_RD;
        else if (!fifo_empty)
            grant = DL_WR;
        else if (pend_valid)
            grant = pend_we ? CPU_WR : CPU_RD;

        case (grant)
            VID:    ram_addr = vid_addr;
            CPU_RD: ram_addr = pend_addr;
            CPU_WR: begin
                ram_addr = pend_addr;
                ram_we   = 1'b1;
                ram_din  = pend_din;
            end
            DL_WR: begin
                ram_addr = AW'(fifo_out.addr);
                ram_we   = 1'b1;
                ram_din  = DW'(fifo_out.data);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= grant;
    end

    assign cpu_grant = (grant == CPU_RD) || (grant == CPU_WR);

    // The pending slot stays occupied through its grant cycle, so a request there is dropped
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_din   <= '0;
            wait_cnt   <= '0;
        end else begin
            if (cpu_grant) begin
                pend_valid <= 1'b0;
            end else if (cpu_req && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_we    <= cpu_we;
                pend_addr  <= cpu_addr;
                pend_din   <= cpu_din;
            end
            if (cpu_grant || !pend_valid)
                wait_cnt <= '0;
            else if (wait_cnt < WW'(MAX_WAIT))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_dout_q  <= '0;
            dl_prev     <= 1'b0;
            dl_overflow <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;
            if (state == CPU_RD) cpu_dout_q <= ram_dout;
            if (fifo_push && fifo_full && !fifo_pop)
                dl_overflow <= 1'b1;
            else if (ioctl_download && !dl_prev)
                dl_overflow <= 1'b0;
        end
    end

    assign vid_valid = (state == VID);
    assign vid_data  = vid_valid ? ram_dout : '0;
    assign cpu_ack   = (state == CPU_RD) || (state == CPU_WR);
    assign cpu_dout  = (state == CPU_RD) ? ram_dout : cpu_dout_q;
    assign dl_busy   = ioctl_download || !fifo_empty;

endmodule

// File: tb/tb_lynx_mem_arbiter.sv
// tb/tb_lynx_mem_arbiter.sv - directed scoreboard bench for lynx_mem_arbiter
module tb_lynx_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = '0;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        dl_busy;
    logic        dl_overflow;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = 8'h00;

    logic [7:0]  mem [0:65535];
    int          total = 0;
    int          bad = 0;
    int          vid_cnt = 0;
    int          ack_cnt = 0;
    int          vid_exp[$];
    int          cpu_exp[$];

    always #5 clk_sys = ~clk_sys;

    lynx_mem_arbiter dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .vid_req        (vid_req),
        .vid_addr       (vid_addr),
        .vid_data       (vid_data),
        .vid_valid      (vid_valid),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_dout       (cpu_dout),
        .cpu_ack        (cpu_ack),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .dl_busy        (dl_busy),
        .dl_overflow    (dl_overflow),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout)
    );

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    always @(negedge clk_sys) begin
        if (vid_valid) begin
            vid_cnt++;
            if (vid_exp.size() == 0) chk("vid_unexpected", vid_valid, 0);
            else chk("vid_data", vid_data, vid_exp.pop_front());
        end
        if (cpu_ack) begin
            int e;
            ack_cnt++;
            if (cpu_exp.size() == 0) chk("ack_unexpected", cpu_ack, 0);
            else begin
                e = cpu_exp.pop_front();
                if (e >= 0) chk("cpu_dout", cpu_dout, e);
            end
        end
    end

    task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [7:0] din,
                          input int exp_rd, input string tag);
        int n;
        cpu_we = we; cpu_addr = addr; cpu_din = din; cpu_req = 1'b1;
        cpu_exp.push_back(we ? -1 : exp_rd);
        tick();
        cpu_req = 1'b0;
        n = 1;
        @(negedge clk_sys);
        while (!cpu_ack && n < 40) begin
            n++;
            @(negedge clk_sys);
        end
        chk(tag, n, 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vid_valid"}, vid_valid, 0);
        chk({tag, "_vid_data"}, vid_data, 0);
        chk({tag, "_cpu_ack"}, cpu_ack, 0);
        chk({tag, "_cpu_dout"}, cpu_dout, 0);
        chk({tag, "_dl_busy"}, dl_busy, 0);
        chk({tag, "_dl_overflow"}, dl_overflow, 0);
        chk({tag, "_ram"}, {ram_we, ram_addr, ram_din}, 0);
    endtask

    initial begin
        int n;
        int v0;
        int a0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8);

        #3;
        check_reset_outputs("rst");
        tick();
        reset_n = 1'b1;
        tick();

        cpu_op(1'b1, 16'h1234, 8'h5A, 0, "wr_latency");
        cpu_op(1'b0, 16'h1234, 8'h00, 8'h5A, "rd_latency");
        tick();
        @(negedge clk_sys);
        chk("cpu_dout_hold", cpu_dout, 8'h5A);

        // video stream starves a pending CPU read
        tick();
        v0 = vid_cnt; a0 = ack_cnt;
        cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
        cpu_exp.push_back(8'h5A);
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vid_req = 1'b1;
            vid_addr = 16'h0100 + 16'(i * 3);
            vid_exp.push_back(int'(mem[vid_addr]));
            tick();
        end
        vid_req = 1'b0;
        chk("no_ack_during_video", ack_cnt, a0);
        n = 1;
        @(negedge clk_sys);
        while (!cpu_ack && n < 40) begin
            n++;
            @(negedge clk_sys);
        end
        chk("ack_after_video", n, 2);
        chk("vid_pulses", vid_cnt - v0, 10);

        // eight-byte download, one per cycle
        tick();
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'h8000 + 25'(i); ioctl_data = 8'(i);
            tick();
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("dl_busy_last", dl_busy, 1);
        tick();
        @(negedge clk_sys);
        chk("dl_busy_drop", dl_busy, 0);
        chk("dl_no_overflow", dl_overflow, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("dl_mem%0d", i), mem[16'h8000 + 16'(i)], i);

        // address above the RAM window is discarded
        tick();
        ioctl_wr = 1'b1; ioctl_addr = 25'h1_8000; ioctl_data = 8'hEE;
        tick();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("dl_high_addr_busy", dl_busy, 0);
        tick(); tick();
        chk("dl_high_addr_mem", mem[16'h8000], 8'h00);

        // overflow under continuous video
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            vid_req = 1'b1;
            vid_addr = 16'h0200 + 16'(i);
            vid_exp.push_back(int'(mem[vid_addr]));
            ioctl_wr = 1'b1; ioctl_addr = 25'h9000 + 25'(i); ioctl_data = 8'h40 + 8'(i);
            tick();
        end
        vid_req = 1'b0; ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("overflow_set", dl_overflow, 1);
        for (int i = 0; i < 6; i++) tick();
        for (int i = 0; i < 4; i++) chk($sformatf("ovf_mem%0d", i), mem[16'h9000 + 16'(i)], 8'h40 + 8'(i));
        chk("ovf_drop5", mem[16'h9004], 8'h94);
        chk("ovf_drop6", mem[16'h9005], 8'h95);
        ioctl_download = 1'b0;
        tick();
        @(negedge clk_sys);
        chk("overflow_sticky", dl_overflow, 1);
        tick();
        ioctl_download = 1'b1;
        tick();
        @(negedge clk_sys);
        chk("overflow_clear", dl_overflow, 0);

        // push into a full FIFO in the same cycle as a pop
        tick();
        for (int i = 0; i < 4; i++) begin
            vid_req = 1'b1;
            vid_addr = 16'h0300 + 16'(i);
            vid_exp.push_back(int'(mem[vid_addr]));
            ioctl_wr = 1'b1; ioctl_addr = 25'hA000 + 25'(i); ioctl_data = 8'h30 + 8'(i);
            tick();
        end
        vid_req = 1'b0;
        ioctl_addr = 25'hA004; ioctl_data = 8'h55;
        tick();
        ioctl_wr = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("full_pushpop_ovf", dl_overflow, 0);
        chk("full_pushpop_mem", mem[16'hA004], 8'h55);
        chk("full_first_mem", mem[16'hA000], 8'h30);

        // FIFO kept busy: the CPU wins after MAX_WAIT waiting cycles
        ioctl_wr = 1'b1; ioctl_addr = 25'hB000; ioctl_data = 8'h70;
        tick();
        cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
        cpu_exp.push_back(8'h5A);
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            ioctl_addr = 25'hB000 + 25'(k); ioctl_data = 8'h70 + 8'(k);
            tick();
            cpu_req = 1'b0;
            @(negedge clk_sys);
            if (cpu_ack && n == 0) n = k;
        end
        ioctl_wr = 1'b0;
        chk("aged_cpu_ack", n, 6);
        for (int i = 0; i < 6; i++) tick();
        chk("aged_dl_mem", mem[16'hB00A], 8'h7A);
        ioctl_download = 1'b0;
        tick();

        // reset while a CPU read has been granted
        a0 = ack_cnt;
        cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
        tick();
        cpu_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        @(negedge clk_sys);
        check_reset_outputs("mid_rst_hold");
        chk("mid_rst_no_ack", ack_cnt, a0);
        tick();
        reset_n = 1'b1;
        tick();
        cpu_op(1'b0, 16'h1234, 8'h00, 8'h5A, "post_rst_rd");
        tick(); tick();

        chk("vid_queue_empty", vid_exp.size(), 0);
        chk("cpu_queue_empty", cpu_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lynx_mem_arbiter.md
# lynx_mem_arbiter

Arbiter sharing one single-port video/system RAM between the Lynx video fetch, the Z80 CPU and the OSD ioctl download stream. Sits between `lynx48`'s memory requesters and the RAM macro, inside the `clk_sys` domain. Video gets fixed top priority. CPU accesses use a pulse/ack handshake. Download bytes are buffered in a small FIFO so tape/ROM loads never stall the HPS.

## Interface
- AW, 16, RAM address width
- DW, 8, RAM data width
- FIFO_DEPTH, 4, download FIFO entries (power of two, ≥2)
- MAX_WAIT, 4, CPU wait cycles before CPU beats download

- clock  in  1  system clock (clk_sys); all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- vid_req  in  1  single-cycle read strobe from video
- vid_addr  in  AW  video read address, valid with vid_req
- vid_data  out  DW  video read data
- vid_valid  out  1  vid_data valid strobe
- cpu_req  in  1  single-cycle access strobe; cpu_we/cpu_addr/cpu_din sampled with it
- cpu_we  in  1  1 = write
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_dout  out  DW  CPU read data, held until next CPU read completes
- cpu_ack  out  1  one-cycle completion strobe (reads and writes)
- ioctl_download  in  1  download window active
- ioctl_wr  in  1  download byte strobe
- ioctl_addr  in  25  download byte address
- ioctl_data  in  8  download byte
- dl_busy  out  1  ioctl_download OR FIFO non-empty
- dl_overflow  out  1  sticky: byte dropped on full FIFO
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data; 1-cycle registered latency

## Operation
- Each cycle at most one RAM command. Grant priority: video > (CPU if wait_cnt ≥ MAX_WAIT) > download FIFO > CPU.
- Video: vid_req is granted in the same cycle. ram_addr=vid_addr, ram_we=0. Back-to-back vid_req every cycle is legal and starves everyone else. That is intentional.
- CPU: cpu_req latches {we,addr,din} into a pending register. A cpu_req arriving while pending or in flight is ignored. wait_cnt increments per cycle pending-not-granted, saturates at MAX_WAIT, and clears on grant.
- Download: ioctl_wr with ioctl_addr < 2^AW pushes {ioctl_addr[AW-1:0], ioctl_data}. Addresses ≥ 2^AW are silently discarded. A push when full drops the byte and sets dl_overflow. The rising edge of ioctl_download clears dl_overflow. Push and pop in the same cycle when full: the pop frees a slot first, so the byte is accepted.
- Grant FSM states: IDLE, VID, CPU_RD, CPU_WR, DL_WR. The state register holds the grant issued this cycle and drives completion next cycle.
- DW is handled as an 8-bit data path only. ioctl_data must match DW.

## Timing
- Grant in cycle N drives ram_* combinationally from the grant decision in N.
- Video: vid_valid=1 and vid_data=ram_dout in N+1.
- CPU read: cpu_ack=1 and cpu_dout updated in N+1.
- CPU write: RAM write in N, cpu_ack=1 in N+1.
- The earliest CPU completion is cpu_req in cycle M, grant in M+1, ack in M+2. The CPU may issue a new cpu_req in the ack cycle.
- A download byte is written no earlier than 1 cycle after its push.
- Reset (async, any time): FSM=IDLE, FIFO empty, pending cleared, wait_cnt=0. All outputs are 0, including cpu_dout, vid_data and dl_overflow. An access in flight at reset produces no ack or valid.

## Structure
- Package `lynx_mem_pkg` holds:
  - the grant_t enum (IDLE, VID, CPU_RD, CPU_WR, DL_WR)
  - the dl_entry_t struct {addr, data}
  - default AW/DW localparams
- Sub-module `lynx_dl_fifo` is a synchronous FIFO of dl_entry_t with push/pop/full/empty, async active-low reset, and FIFO_DEPTH as its parameter.
- Arbiter logic, pending register and wait counter live in the top module.

## Test plan
- CPU write 0x5A to 0x1234, then read 0x1234 with no other traffic: ack at M+2 each time, and cpu_dout=0x5A.
- vid_req every cycle for 10 cycles with a CPU read pending: 10 vid_valid pulses. CPU ack arrives at the 2nd cycle after vid_req stops.
- Download 8 bytes (0x00..0x07 to 0x8000..) at one per cycle with no other traffic. RAM then holds them and dl_overflow stays 0. dl_busy drops 1 cycle after the last write once ioctl_download=0.
- Continuous vid_req with 6 back-to-back ioctl_wr (FIFO_DEPTH=4): bytes 5 and 6 are dropped and dl_overflow=1. A new ioctl_download rising edge clears it.
- FIFO always non-empty plus CPU pending, no video: CPU is granted after exactly MAX_WAIT=4 waiting cycles.
- reset_n low while a CPU read is in flight: no cpu_ack, all outputs 0. After release, a new cpu_req completes normally.
